// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- hazard-control bundle between the 5-stage pipeline and
// pipe_ctrl.
//
// Contract: there is no valid/ready handshake on this bundle. The pipeline
// presents the stage fields every cycle as level signals. pipe_ctrl answers
// in the same cycle with stall/flush/forward controls that are sampled by the
// pipeline registers at the next rising clk edge. No backpressure exists
// beyond the stall outputs themselves.
//
// Modports:
//   master - pipeline side: drives stage fields, receives controls
//   slave  - pipe_ctrl side: receives stage fields, drives controls
interface pipe_ctrl_if;
    // decode stage
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    // execute stage
    logic [4:0] rs1_e;
    logic [4:0] rs2_e;
    logic [4:0] rd_e;
    logic       regwrite_e;
    logic       memread_e;
    logic       branch_taken_e;
    logic       md_start_e;
    // memory / writeback stages
    logic [4:0] rd_m;
    logic       regwrite_m;
    logic [4:0] rd_w;
    logic       regwrite_w;
    // mul/div unit and trap logic
    logic       md_done;
    logic       trap_req;
    // controls back to the pipeline
    logic       stall_f;
    logic       stall_d;
    logic       stall_e;
    logic       flush_d;
    logic       flush_e;
    logic       flush_m;
    logic [1:0] fwd_a_e;
    logic [1:0] fwd_b_e;
    logic       md_busy;
    logic       md_abort;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, regwrite_e, memread_e,
               branch_taken_e, md_start_e, rd_m, regwrite_m, rd_w,
               regwrite_w, md_done, trap_req,
        input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
               fwd_a_e, fwd_b_e, md_busy, md_abort
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, regwrite_e, memread_e,
               branch_taken_e, md_start_e, rd_m, regwrite_m, rd_w,
               regwrite_w, md_done, trap_req,
        output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
               fwd_a_e, fwd_b_e, md_busy, md_abort
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- hazard unit for a 5-stage in-order pipeline.
// Resolves operand forwarding, load-use stalls, taken-branch flushes,
// multi-cycle mul/div stalls and trap flushes, and keeps two saturating
// performance counters.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   p          pipe_ctrl_if.slave: stage fields in, stall/flush/forward out
//   stall_cnt  cycles with stall_f=1 (saturating, CNT_W bits)
//   flush_cnt  cycles with flush_d=1 (saturating, FCNT_W bits)
//   state_dbg  current FSM state (0 = RUN, 1 = MD_WAIT)
module pipe_ctrl #(
    parameter int CNT_W  = 32,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipe_ctrl_if.slave        p,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [FCNT_W-1:0] flush_cnt,
    output logic              state_dbg
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0]  STALL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [FCNT_W-1:0] FLUSH_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_nxt;
    logic   lu;
    logic   md_wait;

    // MEM result is younger than WB, so it wins; x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && rd_m != 5'd0 && rd_m == rs)
            return 2'b10;
        else if (we_w && rd_w != 5'd0 && rd_w == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Load-use only ever lasts one cycle: the stall holds ID while EX is
    // flushed, so the load has moved on to MEM by the next cycle.
    assign lu = p.memread_e && p.rd_e != 5'd0 &&
                (p.rd_e == p.rs1_d || p.rd_e == p.rs2_d);

    // A start and done in the same RUN cycle is a single-cycle op: no wait.
    assign md_wait = (state == RUN     && p.md_start_e && !p.md_done) ||
                     (state == MD_WAIT && !p.md_done);

    assign state_dbg = state;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        if (p.trap_req) begin
            state_nxt = RUN;
        end else if (state == RUN) begin
            // a taken branch outranks the mul/div wait and kills the op
            if (!p.branch_taken_e && md_wait)
                state_nxt = MD_WAIT;
        end else if (p.md_done) begin
            state_nxt = RUN;
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        p.stall_f  = 1'b0;
        p.stall_d  = 1'b0;
        p.stall_e  = 1'b0;
        p.flush_d  = 1'b0;
        p.flush_e  = 1'b0;
        p.flush_m  = 1'b0;
        p.md_abort = 1'b0;
        p.md_busy  = (state == MD_WAIT);
        p.fwd_a_e  = fwd_sel(p.rs1_e, p.rd_m, p.regwrite_m, p.rd_w, p.regwrite_w);
        p.fwd_b_e  = fwd_sel(p.rs2_e, p.rd_m, p.regwrite_m, p.rd_w, p.regwrite_w);

        if (reset) begin
            // load bubbles everywhere while reset is held
            p.flush_d = 1'b1;
            p.flush_e = 1'b1;
            p.flush_m = 1'b1;
            p.fwd_a_e = 2'b00;
            p.fwd_b_e = 2'b00;
        end else if (p.trap_req) begin
            p.flush_d  = 1'b1;
            p.flush_e  = 1'b1;
            p.flush_m  = 1'b1;
            p.md_abort = (state == MD_WAIT);
        end else if (p.branch_taken_e && state == RUN) begin
            p.flush_d = 1'b1;
            p.flush_e = 1'b1;
        end else if (md_wait) begin
            // freeze IF..EX and feed bubbles into MEM
            p.stall_f = 1'b1;
            p.stall_d = 1'b1;
            p.stall_e = 1'b1;
            p.flush_m = 1'b1;
        end else if (lu && state == RUN) begin
            // the MD_WAIT completion cycle releases the pipeline untouched
            p.stall_f = 1'b1;
            p.stall_d = 1'b1;
            p.flush_e = 1'b1;
        end
    end

    // ---------------- performance counters ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (p.stall_f && stall_cnt != '1)
                stall_cnt <= stall_cnt + STALL_ONE;
            if (p.flush_d && flush_cnt != '1)
                flush_cnt <= flush_cnt + FLUSH_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- directed bench for pipe_ctrl.
// Control outputs are packed as {stall_f,stall_d,stall_e,flush_d,flush_e,
// flush_m,fwd_a_e,fwd_b_e,md_busy,md_abort}. Inputs are driven at the falling
// edge, the expected vector is queued at the same time, and the combinational
// outputs are checked 1 ns later, before the next rising edge.
module tb_pipe_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic reset_s;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();
    pipe_ctrl_if bus_s ();

    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic        state_dbg;
    logic [3:0]  stall_cnt_s;
    logic [15:0] flush_cnt_s;
    logic        state_dbg_s;

    pipe_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .p         (bus),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .state_dbg (state_dbg)
    );

    // narrow stall counter instance for the saturation check
    pipe_ctrl #(.CNT_W(4), .FCNT_W(16)) dut_s (
        .clk       (clk),
        .reset     (reset_s),
        .p         (bus_s),
        .stall_cnt (stall_cnt_s),
        .flush_cnt (flush_cnt_s),
        .state_dbg (state_dbg_s)
    );

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [11:0] ctrl_obs;

    assign ctrl_obs = {bus.stall_f, bus.stall_d, bus.stall_e,
                       bus.flush_d, bus.flush_e, bus.flush_m,
                       bus.fwd_a_e, bus.fwd_b_e, bus.md_busy, bus.md_abort};

    function automatic logic [11:0] cv(
        input logic sf, input logic sd, input logic se,
        input logic fd, input logic fe, input logic fm,
        input logic [1:0] fa, input logic [1:0] fb,
        input logic busy, input logic abort
    );
        return {sf, sd, se, fd, fe, fm, fa, fb, busy, abort};
    endfunction

    // check the queued control vector, then advance to the next falling edge
    task automatic check_ctrl(input string tag);
        logic [11:0] e;
        #1;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed %h but scoreboard empty", tag, ctrl_obs);
        end else begin
            e = exp_q.pop_front();
            assert (ctrl_obs === e) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", tag, ctrl_obs, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input logic [11:0] e, input string tag);
        exp_q.push_back(e);
        check_ctrl(tag);
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] obs,
                             input logic [31:0] e);
        n_cmp++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        bus.rs1_d = 5'd0; bus.rs2_d = 5'd0;
        bus.rs1_e = 5'd0; bus.rs2_e = 5'd0; bus.rd_e = 5'd0;
        bus.regwrite_e = 1'b0; bus.memread_e = 1'b0;
        bus.branch_taken_e = 1'b0; bus.md_start_e = 1'b0;
        bus.rd_m = 5'd0; bus.regwrite_m = 1'b0;
        bus.rd_w = 5'd0; bus.regwrite_w = 1'b0;
        bus.md_done = 1'b0; bus.trap_req = 1'b0;
    endtask

    task automatic idle_s();
        bus_s.rs1_d = 5'd0; bus_s.rs2_d = 5'd0;
        bus_s.rs1_e = 5'd0; bus_s.rs2_e = 5'd0; bus_s.rd_e = 5'd0;
        bus_s.regwrite_e = 1'b0; bus_s.memread_e = 1'b0;
        bus_s.branch_taken_e = 1'b0; bus_s.md_start_e = 1'b0;
        bus_s.rd_m = 5'd0; bus_s.regwrite_m = 1'b0;
        bus_s.rd_w = 5'd0; bus_s.regwrite_w = 1'b0;
        bus_s.md_done = 1'b0; bus_s.trap_req = 1'b0;
    endtask

    localparam logic [11:0] IDLE = 12'h000;
    localparam logic [11:0] STL  = 12'b111_001_00_00_0_0; // lu-free mul/div stall, RUN
    localparam logic [11:0] STLB = 12'b111_001_00_00_1_0; // mul/div stall in MD_WAIT

    // ---------------- directed sequence ----------------
    initial begin
        logic [4:0] r;
        int         n_sat;
        idle();
        idle_s();
        reset   = 1'b1;
        reset_s = 1'b1;
        @(negedge clk);

        // reset behaviour
        step(cv(0,0,0,1,1,1,2'b00,2'b00,0,0), "reset_ctrl0");
        bus.rs1_e = 5'd5; bus.rd_m = 5'd5; bus.regwrite_m = 1'b1;
        step(cv(0,0,0,1,1,1,2'b00,2'b00,0,0), "reset_fwd_forced0");
        check_cnt("reset_stall_cnt", stall_cnt, 0);
        check_cnt("reset_flush_cnt", {16'd0, flush_cnt}, 0);
        idle();
        reset = 1'b0;
        step(IDLE, "idle_run");

        // forwarding
        bus.rs1_e = 5'd5; bus.rd_m = 5'd5; bus.regwrite_m = 1'b1;
        bus.rd_w = 5'd5; bus.regwrite_w = 1'b1;
        step(cv(0,0,0,0,0,0,2'b10,2'b00,0,0), "fwd_a_mem_prio");
        bus.regwrite_m = 1'b0;
        step(cv(0,0,0,0,0,0,2'b01,2'b00,0,0), "fwd_a_wb");
        bus.regwrite_m = 1'b1; bus.rd_m = 5'd0; bus.rd_w = 5'd0;
        step(cv(0,0,0,0,0,0,2'b00,2'b00,0,0), "fwd_a_x0");
        r = 5'($urandom_range(1, 31));
        idle();
        bus.rs2_e = r; bus.rd_w = r; bus.regwrite_w = 1'b1;
        step(cv(0,0,0,0,0,0,2'b00,2'b01,0,0), "fwd_b_wb");
        bus.rd_m = r; bus.regwrite_m = 1'b1; bus.rs1_e = r;
        step(cv(0,0,0,0,0,0,2'b10,2'b10,0,0), "fwd_ab_mem");

        // load-use
        idle();
        bus.memread_e = 1'b1; bus.regwrite_e = 1'b1; bus.rd_e = 5'd0;
        bus.rs1_d = 5'd0;
        step(IDLE, "lu_x0_ignored");
        check_cnt("lu_cnt_before", stall_cnt, 0);
        bus.rd_e = 5'd7; bus.rs1_d = 5'd3; bus.rs2_d = 5'd7;
        step(cv(1,1,0,0,1,0,2'b00,2'b00,0,0), "lu_stall");
        idle();
        bus.rs2_d = 5'd7;
        step(IDLE, "lu_bubble_after");
        check_cnt("lu_cnt_after", stall_cnt, 1);

        // divide: start at cycle 0, done at cycle 4
        idle();
        bus.md_start_e = 1'b1;
        step(STL, "div_c0");
        step(STLB, "div_c1");
        step(STLB, "div_c2");
        step(STLB, "div_c3");
        bus.md_done = 1'b1;
        step(cv(0,0,0,0,0,0,2'b00,2'b00,1,0), "div_c4_done");
        idle();
        step(IDLE, "div_back_run");
        check_cnt("div_stall_cnt", stall_cnt, 5);

        // trap during divide
        bus.md_start_e = 1'b1;
        step(STL, "trap_div_c0");
        step(STLB, "trap_div_w1");
        bus.trap_req = 1'b1;
        step(cv(0,0,0,1,1,1,2'b00,2'b00,1,1), "trap_abort");
        idle();
        step(IDLE, "trap_back_run");
        check_cnt("trap_stall_cnt", stall_cnt, 7);
        check_cnt("trap_flush_cnt", {16'd0, flush_cnt}, 1);

        // branch beats load-use
        bus.branch_taken_e = 1'b1; bus.memread_e = 1'b1;
        bus.rd_e = 5'd7; bus.rs1_d = 5'd7;
        step(cv(0,0,0,1,1,0,2'b00,2'b00,0,0), "branch_over_lu");
        idle();
        step(IDLE, "branch_after");
        check_cnt("branch_flush_cnt", {16'd0, flush_cnt}, 2);
        check_cnt("branch_stall_cnt", stall_cnt, 7);

        // branch ignored in MD_WAIT
        bus.md_start_e = 1'b1;
        step(STL, "mdbr_c0");
        bus.branch_taken_e = 1'b1;
        step(STLB, "mdbr_ignored");
        bus.branch_taken_e = 1'b0; bus.md_done = 1'b1;
        step(cv(0,0,0,0,0,0,2'b00,2'b00,1,0), "mdbr_done");
        idle();
        step(IDLE, "mdbr_back_run");
        check_cnt("mdbr_flush_cnt", {16'd0, flush_cnt}, 2);
        check_cnt("mdbr_stall_cnt", stall_cnt, 9);

        // single-cycle mul/div
        bus.md_start_e = 1'b1; bus.md_done = 1'b1;
        step(IDLE, "md_start_done");
        idle();
        step(IDLE, "md_start_done_stays_run");

        // reset while in MD_WAIT
        bus.md_start_e = 1'b1;
        step(STL, "rstmd_c0");
        reset = 1'b1;
        step(cv(0,0,0,1,1,1,2'b00,2'b00,1,0), "rstmd_no_abort");
        reset = 1'b0;
        idle();
        step(IDLE, "rstmd_back_run");
        check_cnt("rstmd_stall_cnt", stall_cnt, 0);
        check_cnt("rstmd_flush_cnt", {16'd0, flush_cnt}, 0);

        // saturation on the 4-bit stall counter
        reset_s = 1'b0;
        bus_s.memread_e = 1'b1; bus_s.rd_e = 5'd9; bus_s.rs1_d = 5'd9;
        n_sat = 20 + int'($urandom_range(0, 4));
        for (int i = 0; i < n_sat; i++) @(negedge clk);
        check_cnt("sat_stall_cnt", {28'd0, stall_cnt_s}, 15);
        reset_s = 1'b1;
        @(negedge clk);
        check_cnt("sat_reset_clears", {28'd0, stall_cnt_s}, 0);
        idle_s();

        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of the stall-cycle counter.
REQ-002 The block SHALL have parameter FCNT_W, default 16, giving the width of the flush-event counter.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rs1_d, rs2_d  in  5 each  decode-stage source registers.
REQ-006 rs1_e, rs2_e, rd_e  in  5 each  execute-stage sources and destination.
REQ-007 regwrite_e, memread_e  in  1 each  execute-stage instruction writes rd / is a load.
REQ-008 rd_m, regwrite_m  in  5, 1  memory-stage destination and write enable.
REQ-009 rd_w, regwrite_w  in  5, 1  writeback-stage destination and write enable.
REQ-010 branch_taken_e  in  1  execute-stage redirect (taken branch or jump).
REQ-011 md_start_e  in  1  a mul/div operation occupies the execute stage.
REQ-012 md_done  in  1  the mul/div unit result is valid this cycle.
REQ-013 trap_req  in  1  exception or interrupt taken in the memory stage.
REQ-014 stall_f, stall_d, stall_e  out  1 each  hold the IF, ID and EX pipeline registers.
REQ-015 flush_d, flush_e, flush_m  out  1 each  load the default value into the ID, EX and MEM pipeline registers.
REQ-016 fwd_a_e, fwd_b_e  out  2 each  operand forwarding selects: 00 = register file, 01 = WB, 10 = MEM.
REQ-017 md_busy, md_abort  out  1 each  FSM is in MD_WAIT / mul/div operation cancelled.
REQ-018 stall_cnt, flush_cnt  out  CNT_W, FCNT_W  performance counters.

Function
REQ-019 The FSM SHALL have two states, RUN and MD_WAIT, and md_busy SHALL equal (state==MD_WAIT).
REQ-020 Every output other than stall_cnt and flush_cnt SHALL be combinational from the current state and the current inputs, so that it takes effect at the same clock edge.
REQ-021 fwd_a_e SHALL be:
- 10 when regwrite_m && rd_m!=0 && rd_m==rs1_e;
- otherwise 01 when regwrite_w && rd_w!=0 && rd_w==rs1_e;
- otherwise 00.
- fwd_b_e SHALL be the same function with rs2_e; MEM SHALL take priority over WB.
REQ-022 Load-use (lu) SHALL be detected when memread_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
REQ-023 Control priority SHALL be trap_req > branch_taken_e > mul/div wait > lu; only the highest active condition SHALL drive the stall and flush outputs.
REQ-024 trap_req: flush_d=flush_e=flush_m=1 and all stalls=0; next state SHALL be RUN; md_abort SHALL be 1 only if the state is MD_WAIT.
REQ-025 branch_taken_e: flush_d=flush_e=1, flush_m=0, all stalls=0; in MD_WAIT, branch_taken_e SHALL be ignored.
REQ-026 Mul/div wait SHALL be active when (state==RUN && md_start_e && !md_done) or (state==MD_WAIT && !md_done).
- While active: stall_f=stall_d=stall_e=1, flush_m=1 (bubble), flush_d=flush_e=0.
- In RUN, the next state SHALL be MD_WAIT.
REQ-027 In MD_WAIT with md_done=1: all stalls and flushes SHALL be 0 and the next state SHALL be RUN.
REQ-028 md_start_e && md_done in the same RUN cycle SHALL cause no stall and no state change.
REQ-029 lu: stall_f=stall_d=1, flush_e=1, stall_e=0; lu SHALL last exactly one cycle per load.
REQ-030 When no condition is active, all stall and flush outputs SHALL be 0.
REQ-031 stall_cnt SHALL increment by 1 on every cycle stall_f=1 and SHALL saturate at all-ones.
REQ-032 flush_cnt SHALL increment by 1 on every cycle flush_d=1 and SHALL saturate at all-ones.
REQ-033 Writes to x0 SHALL never cause forwarding or load-use detection.

Reset
REQ-034 While reset=1:
- state SHALL become RUN on the next edge and both counters SHALL become 0;
- stall_f/d/e=0, flush_d/e/m=1, md_abort=0, fwd selects=00.
REQ-035 Reset asserted in MD_WAIT SHALL return the FSM to RUN without asserting md_abort.
REQ-036 Counters SHALL NOT increment while reset=1.

Verification
REQ-037 Forwarding:
- rs1_e=5, rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1 -> fwd_a_e=10;
- drop regwrite_m -> fwd_a_e=01;
- rd_m=rd_w=0 -> fwd_a_e=00.
REQ-038 Load-use: memread_e=1, rd_e=7, rs2_d=7 -> exactly one cycle with stall_f=stall_d=flush_e=1; stall_cnt increments 0->1.
REQ-039 Divide: md_start_e=1 at cycle 0, md_done=1 at cycle 4 -> md_busy=1 in cycles 1-4; stalls=1 in cycles 0-3 and 0 in cycle 4; stall_cnt=4.
REQ-040 Trap during divide: trap_req=1 in cycle 2 of MD_WAIT -> flush_d/e/m=1 and md_abort=1 for one cycle; state RUN in the next cycle.
REQ-041 Simultaneous branch_taken_e=1 and lu in RUN -> flush_d=flush_e=1, stall_f=0, flush_cnt+1.
REQ-042 Saturation: with CNT_W=4, 20 stall cycles -> stall_cnt=15; reset=1 -> stall_cnt=0 next cycle.
